// File: rtl/spm_copy_if.sv
// Command and scratchpad-port signal bundle for spm_copy_engine.
// io_cycles exists only when SPM_COPY_PERF_EN is defined.
interface spm_copy_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              io_cmd_valid;
  logic              io_cmd_ready;
  logic              io_cmd_fill;
  logic [ADDR_W-1:0] io_cmd_src;
  logic [ADDR_W-1:0] io_cmd_dst;
  logic [ADDR_W:0]   io_cmd_len;
  logic [BE_W-1:0]   io_cmd_byteEn;
  logic [DATA_W-1:0] io_cmd_pattern;
  logic [DATA_W-1:0] io_M_Data;
  logic [ADDR_W-1:0] io_M_Addr;
  logic [BE_W-1:0]   io_M_ByteEn;
  logic              io_M_We;
  logic [DATA_W-1:0] io_S_Data;
  logic              io_busy;
  logic              io_done;
`ifdef SPM_COPY_PERF_EN
  logic [15:0]       io_cycles;
`endif

  // master: the copy engine; slave: the controller and SPM around it
  modport master (
    input  io_cmd_valid, io_cmd_fill, io_cmd_src, io_cmd_dst, io_cmd_len,
           io_cmd_byteEn, io_cmd_pattern, io_S_Data,
`ifdef SPM_COPY_PERF_EN
    output io_cycles,
`endif
    output io_cmd_ready, io_M_Data, io_M_Addr, io_M_ByteEn, io_M_We,
           io_busy, io_done
  );

  modport slave (
    output io_cmd_valid, io_cmd_fill, io_cmd_src, io_cmd_dst, io_cmd_len,
           io_cmd_byteEn, io_cmd_pattern, io_S_Data,
`ifdef SPM_COPY_PERF_EN
    input  io_cycles,
`endif
    input  io_cmd_ready, io_M_Data, io_M_Addr, io_M_ByteEn, io_M_We,
           io_busy, io_done
  );
endinterface

// File: rtl/spm_copy_engine.sv
// SPM block-copy / pattern-fill initiator driving a byte-enabled scratchpad port.
// Define SPM_COPY_PERF_EN to add the io_cycles command-duration counter.
//
// state | meaning
// IDLE  | waiting for a command, io_cmd_ready high
// RD    | read address src+cnt presented
// CAP   | SPM returns read data, captured into the write-data register
// WR    | write dst+cnt with latched byte enables
// DONE  | one-cycle completion pulse
module spm_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic        clk,
  input logic        reset,
  spm_copy_if.master bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, cnt_inc, len_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] pat_q;
  logic              fill_q;
  logic              accept;

  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [BE_W-1:0]   m_be_q, m_be_d;
  logic              m_we_q, m_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  assign bus.io_cmd_ready = (state_q == IDLE);
  assign accept           = bus.io_cmd_valid && bus.io_cmd_ready;
  assign cnt_inc          = cnt_q + CNT_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      m_data_q <= '0;
      m_addr_q <= '0;
      m_be_q   <= '0;
      m_we_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_data_q <= m_data_d;
      m_addr_q <= m_addr_d;
      m_be_q   <= m_be_d;
      m_we_q   <= m_we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      be_q   <= '0;
      pat_q  <= '0;
      fill_q <= 1'b0;
    end else if (accept) begin
      src_q  <= bus.io_cmd_src;
      dst_q  <= bus.io_cmd_dst;
      len_q  <= bus.io_cmd_len;
      be_q   <= bus.io_cmd_byteEn;
      pat_q  <= bus.io_cmd_pattern;
      fill_q <= bus.io_cmd_fill;
    end
  end

  // Master outputs are computed for the state being entered, so they are
  // registered yet line up with that state's cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_data_d = m_data_q;
    m_addr_d = m_addr_q;
    m_be_d   = '0;
    m_we_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (bus.io_cmd_len == '0) begin
            state_d = DONE;
          end else if (bus.io_cmd_fill) begin
            state_d  = WR;
            m_addr_d = bus.io_cmd_dst;
            m_data_d = bus.io_cmd_pattern;
            m_be_d   = bus.io_cmd_byteEn;
            m_we_d   = 1'b1;
          end else begin
            state_d  = RD;
            m_addr_d = bus.io_cmd_src;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        state_d  = WR;
        m_addr_d = dst_q + cnt_q[ADDR_W-1:0];
        m_data_d = bus.io_S_Data;
        m_be_d   = be_q;
        m_we_d   = 1'b1;
      end
      WR: begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) begin
          state_d = DONE;
        end else if (fill_q) begin
          m_addr_d = dst_q + cnt_inc[ADDR_W-1:0];
          m_data_d = pat_q;
          m_be_d   = be_q;
          m_we_d   = 1'b1;
        end else begin
          state_d  = RD;
          m_addr_d = src_q + cnt_inc[ADDR_W-1:0];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RD) || (state_d == CAP) || (state_d == WR);
    done_d = (state_d == DONE);
  end

  assign bus.io_M_Data   = m_data_q;
  assign bus.io_M_Addr   = m_addr_q;
  assign bus.io_M_ByteEn = m_be_q;
  assign bus.io_M_We     = m_we_q;
  assign bus.io_busy     = busy_q;
  assign bus.io_done     = done_q;

`ifdef SPM_COPY_PERF_EN
  // Counts through the DONE cycle so the value equals accept-to-done latency.
  logic [15:0] cycles_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cycles_q <= '0;
    else if (accept)
      cycles_q <= '0;
    else if (state_q != IDLE && cycles_q != 16'hFFFF)
      cycles_q <= cycles_q + 16'd1;
  end
  assign bus.io_cycles = cycles_q;
`endif
endmodule
